// File: rtl/ins_mem_pkg.sv
// Shared encodings for the memory-access stage: FSM states, funct3 access
// codes and writeback-select values.
package ins_mem_pkg;

  typedef enum logic [1:0] {
    IDLE     = 2'd0,
    WAIT_GNT = 2'd1,
    WAIT_RSP = 2'd2
  } state_t;

  localparam logic [2:0] F3_LB  = 3'b000;
  localparam logic [2:0] F3_LH  = 3'b001;
  localparam logic [2:0] F3_LW  = 3'b010;
  localparam logic [2:0] F3_LBU = 3'b100;
  localparam logic [2:0] F3_LHU = 3'b101;
  localparam logic [2:0] F3_SB  = 3'b000;
  localparam logic [2:0] F3_SH  = 3'b001;
  localparam logic [2:0] F3_SW  = 3'b010;

  localparam logic [1:0] WB_ALU  = 2'b00;
  localparam logic [1:0] WB_LOAD = 2'b01;
  localparam logic [1:0] WB_PC4  = 2'b10;

endpackage

// File: rtl/ins_mem_load_store_align.sv
// Byte-lane handling for loads and stores: misalignment detection, store
// strobe/data replication and load byte/half extraction with extension.
module load_store_align
  import ins_mem_pkg::*;
(
  input  logic [1:0]  offset,
  input  logic [2:0]  funct3,
  input  logic        store,
  input  logic [31:0] store_data,
  input  logic [31:0] rdata,
  output logic        misaligned,
  output logic [3:0]  wstrb,
  output logic [31:0] wdata,
  output logic [31:0] load_data
);

  logic [31:0] shifted;

  always_comb begin
    misaligned = 1'b0;
    case (funct3[1:0])
      2'b00:   misaligned = 1'b0;
      2'b01:   misaligned = offset[0];
      default: misaligned = |offset;
    endcase
  end

  // Byte and half stores are replicated across lanes; the strobe picks the lane.
  always_comb begin
    wstrb = 4'b0000;
    wdata = store_data;
    case (funct3[1:0])
      2'b00: begin
        wstrb = 4'b0001 << offset;
        wdata = {4{store_data[7:0]}};
      end
      2'b01: begin
        wstrb = 4'b0011 << offset;
        wdata = {2{store_data[15:0]}};
      end
      default: begin
        wstrb = 4'b1111;
        wdata = store_data;
      end
    endcase
    if (!store) wstrb = 4'b0000;
  end

  always_comb begin
    shifted   = rdata >> {offset, 3'b000};
    load_data = shifted;
    case (funct3)
      F3_LB:   load_data = {{24{shifted[7]}}, shifted[7:0]};
      F3_LH:   load_data = {{16{shifted[15]}}, shifted[15:0]};
      F3_LBU:  load_data = {24'd0, shifted[7:0]};
      F3_LHU:  load_data = {16'd0, shifted[15:0]};
      default: load_data = shifted;
    endcase
  end

endmodule

// File: rtl/ins_mem.sv
// Memory-access pipeline stage: issues loads/stores on the shared data port,
// stalls while outstanding, and produces the MEM/WB register.
module ins_mem
  import ins_mem_pkg::*;
#(
  parameter logic [1:0] CORE_ID    = 2'd0,
  parameter int         WAIT_LIMIT = 255
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [31:0] ex_pc_plus_4_in,
  input  logic [31:0] ex_alu_result_in,
  input  logic [31:0] ex_read_data2_in,
  input  logic [4:0]  ex_rd_addr_in,
  input  logic [2:0]  ex_funct3_in,
  input  logic        ex_mem_read_in,
  input  logic        ex_mem_write_in,
  input  logic        ex_reg_write_in,
  input  logic [1:0]  ex_mem_to_reg_in,
  output logic        dmem_req_out,
  output logic        dmem_we_out,
  output logic [31:0] dmem_addr_out,
  output logic [31:0] dmem_wdata_out,
  output logic [3:0]  dmem_wstrb_out,
  output logic [1:0]  dmem_core_id_out,
  input  logic        dmem_gnt_in,
  input  logic        dmem_rvalid_in,
  input  logic [31:0] dmem_rdata_in,
  output logic        mem_stall_out,
  output logic [31:0] mem_forward_data_out,
  output logic [31:0] mem_pc_plus_4_out,
  output logic [31:0] mem_alu_result_out,
  output logic [31:0] mem_read_data_out,
  output logic [4:0]  mem_rd_addr_out,
  output logic        mem_reg_write_out,
  output logic [1:0]  mem_mem_to_reg_out,
  output logic        mem_misaligned_out,
  output logic        mem_bus_err_out
);

  localparam int CW = (WAIT_LIMIT > 1) ? $clog2(WAIT_LIMIT + 1) : 1;

  state_t        state;
  logic [CW-1:0] wait_cnt;
  logic          access, is_write, misaligned, aligned_access, misaligned_access;
  logic          timeout, abort, load_done;
  logic [31:0]   load_data;

  assign access            = ex_mem_read_in | ex_mem_write_in;
  assign is_write          = ex_mem_write_in & ~ex_mem_read_in;
  assign aligned_access    = access & ~misaligned;
  assign misaligned_access = access & misaligned & (state == IDLE);

  load_store_align u_align (
    .offset     (ex_alu_result_in[1:0]),
    .funct3     (ex_funct3_in),
    .store      (is_write),
    .store_data (ex_read_data2_in),
    .rdata      (dmem_rdata_in),
    .misaligned (misaligned),
    .wstrb      (dmem_wstrb_out),
    .wdata      (dmem_wdata_out),
    .load_data  (load_data)
  );

  assign dmem_we_out          = is_write;
  assign dmem_addr_out        = {ex_alu_result_in[31:2], 2'b00};
  assign dmem_core_id_out     = CORE_ID;
  assign mem_forward_data_out = ex_alu_result_in;

  // A timeout takes priority over a grant or response arriving in the same cycle.
  always_comb begin
    dmem_req_out  = 1'b0;
    mem_stall_out = 1'b0;
    abort         = 1'b0;
    load_done     = 1'b0;
    timeout       = (WAIT_LIMIT != 0) && (wait_cnt == CW'(WAIT_LIMIT));
    case (state)
      IDLE: begin
        if (aligned_access) begin
          dmem_req_out  = 1'b1;
          mem_stall_out = !(dmem_gnt_in && is_write);
        end
      end
      WAIT_GNT: begin
        if (timeout) abort = 1'b1;
        else begin
          dmem_req_out  = 1'b1;
          mem_stall_out = !(dmem_gnt_in && is_write);
        end
      end
      WAIT_RSP: begin
        if (timeout) abort = 1'b1;
        else begin
          mem_stall_out = !dmem_rvalid_in;
          load_done     = dmem_rvalid_in;
        end
      end
      default: ;
    endcase
    if (!rst) begin
      dmem_req_out  = 1'b0;
      mem_stall_out = 1'b0;
      abort         = 1'b0;
      load_done     = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      state              <= IDLE;
      wait_cnt           <= '0;
      mem_pc_plus_4_out  <= '0;
      mem_alu_result_out <= '0;
      mem_read_data_out  <= '0;
      mem_rd_addr_out    <= '0;
      mem_reg_write_out  <= 1'b0;
      mem_mem_to_reg_out <= '0;
      mem_misaligned_out <= 1'b0;
      mem_bus_err_out    <= 1'b0;
    end else begin
      mem_misaligned_out <= misaligned_access;
      mem_bus_err_out    <= abort;
      wait_cnt           <= (state == IDLE) ? '0 : wait_cnt + 1'b1;

      case (state)
        IDLE:
          if (aligned_access) begin
            if (!dmem_gnt_in)  state <= WAIT_GNT;
            else if (!is_write) state <= WAIT_RSP;
          end
        WAIT_GNT:
          if (abort) state <= IDLE;
          else if (dmem_gnt_in) state <= is_write ? IDLE : WAIT_RSP;
        WAIT_RSP:
          if (abort || dmem_rvalid_in) state <= IDLE;
        default: state <= IDLE;
      endcase

      // Stalled or aborted cycles leave a bubble; other MEM/WB fields hold.
      if (abort || mem_stall_out) begin
        mem_reg_write_out <= 1'b0;
        mem_rd_addr_out   <= '0;
      end else begin
        mem_pc_plus_4_out  <= ex_pc_plus_4_in;
        mem_alu_result_out <= ex_alu_result_in;
        mem_rd_addr_out    <= ex_rd_addr_in;
        mem_reg_write_out  <= ex_reg_write_in & ~misaligned_access;
        mem_mem_to_reg_out <= ex_mem_to_reg_in;
        if (load_done) mem_read_data_out <= load_data;
      end
    end
  end

endmodule

// File: tb/tb_ins_mem.sv
// Directed testbench for ins_mem: ALU pass-through, stores, loads with
// grant/response waits, misalignment, timeout abort and reset abort.
module tb_ins_mem;

  logic        clk = 1'b0;
  logic        rst;
  logic [31:0] ex_pc_plus_4_in, ex_alu_result_in, ex_read_data2_in;
  logic [4:0]  ex_rd_addr_in;
  logic [2:0]  ex_funct3_in;
  logic        ex_mem_read_in, ex_mem_write_in, ex_reg_write_in;
  logic [1:0]  ex_mem_to_reg_in;
  logic        dmem_req_out, dmem_we_out;
  logic [31:0] dmem_addr_out, dmem_wdata_out;
  logic [3:0]  dmem_wstrb_out;
  logic [1:0]  dmem_core_id_out;
  logic        dmem_gnt_in, dmem_rvalid_in;
  logic [31:0] dmem_rdata_in;
  logic        mem_stall_out;
  logic [31:0] mem_forward_data_out, mem_pc_plus_4_out, mem_alu_result_out, mem_read_data_out;
  logic [4:0]  mem_rd_addr_out;
  logic        mem_reg_write_out;
  logic [1:0]  mem_mem_to_reg_out;
  logic        mem_misaligned_out, mem_bus_err_out;

  int checks   = 0;
  int failures = 0;

  always #5 clk = ~clk;

  ins_mem #(.CORE_ID(2'd2), .WAIT_LIMIT(4)) dut (
    .clk                  (clk),
    .rst                  (rst),
    .ex_pc_plus_4_in      (ex_pc_plus_4_in),
    .ex_alu_result_in     (ex_alu_result_in),
    .ex_read_data2_in     (ex_read_data2_in),
    .ex_rd_addr_in        (ex_rd_addr_in),
    .ex_funct3_in         (ex_funct3_in),
    .ex_mem_read_in       (ex_mem_read_in),
    .ex_mem_write_in      (ex_mem_write_in),
    .ex_reg_write_in      (ex_reg_write_in),
    .ex_mem_to_reg_in     (ex_mem_to_reg_in),
    .dmem_req_out         (dmem_req_out),
    .dmem_we_out          (dmem_we_out),
    .dmem_addr_out        (dmem_addr_out),
    .dmem_wdata_out       (dmem_wdata_out),
    .dmem_wstrb_out       (dmem_wstrb_out),
    .dmem_core_id_out     (dmem_core_id_out),
    .dmem_gnt_in          (dmem_gnt_in),
    .dmem_rvalid_in       (dmem_rvalid_in),
    .dmem_rdata_in        (dmem_rdata_in),
    .mem_stall_out        (mem_stall_out),
    .mem_forward_data_out (mem_forward_data_out),
    .mem_pc_plus_4_out    (mem_pc_plus_4_out),
    .mem_alu_result_out   (mem_alu_result_out),
    .mem_read_data_out    (mem_read_data_out),
    .mem_rd_addr_out      (mem_rd_addr_out),
    .mem_reg_write_out    (mem_reg_write_out),
    .mem_mem_to_reg_out   (mem_mem_to_reg_out),
    .mem_misaligned_out   (mem_misaligned_out),
    .mem_bus_err_out      (mem_bus_err_out)
  );

  task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
    checks++;
    assert (observed === expected)
    else begin
      failures++;
      $error("[TB] FAIL %s: observed=%0h expected=%0h", tag, observed, expected);
    end
  endtask

  // Drives one EX/MEM instruction plus the memory-port handshake inputs at the negedge.
  task automatic applyStimulus(input logic rd_en, input logic wr_en, input logic [2:0] f3,
                               input logic [31:0] addr, input logic [31:0] sdata,
                               input logic [4:0] rd, input logic rw, input logic [1:0] m2r,
                               input logic gnt, input logic rvalid, input logic [31:0] rdata);
    @(negedge clk);
    ex_mem_read_in   = rd_en;
    ex_mem_write_in  = wr_en;
    ex_funct3_in     = f3;
    ex_alu_result_in = addr;
    ex_read_data2_in = sdata;
    ex_rd_addr_in    = rd;
    ex_reg_write_in  = rw;
    ex_mem_to_reg_in = m2r;
    dmem_gnt_in      = gnt;
    dmem_rvalid_in   = rvalid;
    dmem_rdata_in    = rdata;
    #1;
  endtask

  task automatic nextEdge();
    @(posedge clk);
    #1;
  endtask

  initial begin
    rst = 1'b0;
    ex_pc_plus_4_in = 32'h0;
    applyStimulus(0, 0, 3'b000, 32'h0, 32'h0, 5'd0, 0, 2'b00, 0, 0, 32'h0);
    nextEdge();
    nextEdge();
    checkOutput("reset_req", 32'(dmem_req_out), 32'd0);
    checkOutput("reset_stall", 32'(mem_stall_out), 32'd0);
    checkOutput("reset_alu", mem_alu_result_out, 32'h0);
    checkOutput("reset_regwrite", 32'(mem_reg_write_out), 32'd0);
    checkOutput("reset_buserr", 32'(mem_bus_err_out), 32'd0);
    checkOutput("core_id", 32'(dmem_core_id_out), 32'd2);

    // ALU op
    rst = 1'b1;
    ex_pc_plus_4_in = 32'h104;
    applyStimulus(0, 0, 3'b000, 32'h1234, 32'h0, 5'd5, 1, 2'b00, 0, 0, 32'h0);
    checkOutput("alu_stall", 32'(mem_stall_out), 32'd0);
    checkOutput("alu_req", 32'(dmem_req_out), 32'd0);
    checkOutput("alu_forward", mem_forward_data_out, 32'h1234);
    nextEdge();
    checkOutput("alu_result", mem_alu_result_out, 32'h1234);
    checkOutput("alu_regwrite", 32'(mem_reg_write_out), 32'd1);
    checkOutput("alu_rd", 32'(mem_rd_addr_out), 32'd5);
    checkOutput("alu_pc4", mem_pc_plus_4_out, 32'h104);

    // SB to 0x1003 granted immediately
    applyStimulus(0, 1, 3'b000, 32'h1003, 32'h000000AB, 5'd0, 0, 2'b00, 1, 0, 32'h0);
    checkOutput("sb_req", 32'(dmem_req_out), 32'd1);
    checkOutput("sb_we", 32'(dmem_we_out), 32'd1);
    checkOutput("sb_addr", dmem_addr_out, 32'h1000);
    checkOutput("sb_wstrb", 32'(dmem_wstrb_out), 32'b1000);
    checkOutput("sb_wdata", dmem_wdata_out, 32'hABABABAB);
    checkOutput("sb_stall", 32'(mem_stall_out), 32'd0);

    // SH to 0x1002, comb lanes only
    applyStimulus(0, 1, 3'b001, 32'h1002, 32'h1234CDEF, 5'd0, 0, 2'b00, 1, 0, 32'h0);
    checkOutput("sh_wstrb", 32'(dmem_wstrb_out), 32'b1100);
    checkOutput("sh_wdata", dmem_wdata_out, 32'hCDEFCDEF);
    nextEdge();

    // LB from 0x2002: two cycles without grant, grant, then rvalid
    applyStimulus(1, 0, 3'b000, 32'h2002, 32'h0, 5'd7, 1, 2'b01, 0, 0, 32'h0);
    checkOutput("lb_c0_req", 32'(dmem_req_out), 32'd1);
    checkOutput("lb_c0_stall", 32'(mem_stall_out), 32'd1);
    checkOutput("lb_wstrb", 32'(dmem_wstrb_out), 32'd0);
    nextEdge();
    checkOutput("lb_c0_bubble_rw", 32'(mem_reg_write_out), 32'd0);
    checkOutput("lb_c0_bubble_rd", 32'(mem_rd_addr_out), 32'd0);
    applyStimulus(1, 0, 3'b000, 32'h2002, 32'h0, 5'd7, 1, 2'b01, 0, 0, 32'h0);
    checkOutput("lb_c1_req", 32'(dmem_req_out), 32'd1);
    checkOutput("lb_c1_stall", 32'(mem_stall_out), 32'd1);
    applyStimulus(1, 0, 3'b000, 32'h2002, 32'h0, 5'd7, 1, 2'b01, 1, 0, 32'h0);
    checkOutput("lb_c2_stall", 32'(mem_stall_out), 32'd1);
    applyStimulus(1, 0, 3'b000, 32'h2002, 32'h0, 5'd7, 1, 2'b01, 0, 1, 32'h00800000);
    checkOutput("lb_c3_req", 32'(dmem_req_out), 32'd0);
    checkOutput("lb_c3_stall", 32'(mem_stall_out), 32'd0);
    nextEdge();
    checkOutput("lb_rdata", mem_read_data_out, 32'hFFFFFF80);
    checkOutput("lb_regwrite", 32'(mem_reg_write_out), 32'd1);
    checkOutput("lb_rd", 32'(mem_rd_addr_out), 32'd7);
    checkOutput("lb_m2r", 32'(mem_mem_to_reg_out), 32'd1);

    // Misaligned LW
    applyStimulus(1, 0, 3'b010, 32'h3002, 32'h0, 5'd9, 1, 2'b01, 0, 0, 32'h0);
    checkOutput("mis_req", 32'(dmem_req_out), 32'd0);
    checkOutput("mis_stall", 32'(mem_stall_out), 32'd0);
    nextEdge();
    checkOutput("mis_pulse", 32'(mem_misaligned_out), 32'd1);
    checkOutput("mis_regwrite", 32'(mem_reg_write_out), 32'd0);
    applyStimulus(0, 0, 3'b000, 32'h0, 32'h0, 5'd0, 0, 2'b00, 0, 0, 32'h0);
    nextEdge();
    checkOutput("mis_pulse_end", 32'(mem_misaligned_out), 32'd0);

    // Timeout: granted LW with no response; four stalled wait cycles then abort
    applyStimulus(1, 0, 3'b010, 32'h4000, 32'h0, 5'd3, 1, 2'b01, 1, 0, 32'h0);
    checkOutput("to_c0_stall", 32'(mem_stall_out), 32'd1);
    for (int i = 1; i <= 4; i++) begin
      applyStimulus(1, 0, 3'b010, 32'h4000, 32'h0, 5'd3, 1, 2'b01, 0, 0, 32'h0);
      checkOutput("to_wait_stall", 32'(mem_stall_out), 32'd1);
    end
    applyStimulus(1, 0, 3'b010, 32'h4000, 32'h0, 5'd3, 1, 2'b01, 0, 0, 32'h0);
    checkOutput("to_abort_stall", 32'(mem_stall_out), 32'd0);
    checkOutput("to_abort_req", 32'(dmem_req_out), 32'd0);
    nextEdge();
    checkOutput("to_buserr", 32'(mem_bus_err_out), 32'd1);
    checkOutput("to_regwrite", 32'(mem_reg_write_out), 32'd0);
    applyStimulus(0, 0, 3'b000, 32'h0, 32'h0, 5'd0, 0, 2'b00, 0, 1, 32'h000000FF);
    checkOutput("stray_stall", 32'(mem_stall_out), 32'd0);
    nextEdge();
    checkOutput("buserr_end", 32'(mem_bus_err_out), 32'd0);
    checkOutput("stray_rdata", mem_read_data_out, 32'hFFFFFF80);

    // Reset while waiting for a response
    applyStimulus(1, 0, 3'b010, 32'h5000, 32'h0, 5'd4, 1, 2'b01, 1, 0, 32'h0);
    nextEdge();
    rst = 1'b0;
    applyStimulus(1, 0, 3'b010, 32'h5000, 32'h0, 5'd4, 1, 2'b01, 0, 0, 32'h0);
    checkOutput("rstw_req_low", 32'(dmem_req_out), 32'd0);
    nextEdge();
    checkOutput("rstw_req", 32'(dmem_req_out), 32'd0);
    checkOutput("rstw_stall", 32'(mem_stall_out), 32'd0);
    checkOutput("rstw_alu", mem_alu_result_out, 32'h0);
    checkOutput("rstw_rdata", mem_read_data_out, 32'h0);
    checkOutput("rstw_regwrite", 32'(mem_reg_write_out), 32'd0);
    rst = 1'b1;
    applyStimulus(1, 0, 3'b010, 32'h5000, 32'h0, 5'd4, 1, 2'b01, 0, 0, 32'h0);
    checkOutput("rstw_idle_req", 32'(dmem_req_out), 32'd1);
    checkOutput("rstw_idle_stall", 32'(mem_stall_out), 32'd1);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
